// File: rtl/bram_pingpong_reader.sv
// bram_pingpong_reader
//   Drain side of a two-bank ping-pong BRAM buffer. Banks are read out in
//   strict alternation, starting with BRAM2. Each bank is streamed as DEPTH
//   words on a valid/ready interface. The bank is then handed back to the
//   writer with a one-cycle free pulse.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   full_1 / full_2     level from the writer: bank holds DEPTH words
//   rd_en_x / rd_add_x  BRAM read port for bank x (data returns next cycle)
//   rd_data_x           BRAM read data for bank x
//   out_valid/out_ready stream handshake
//   out_data/out_last   stream word, last flags the final word of a bank
//   free_1 / free_2     one-cycle pulse: bank drained, writer may refill
//   busy                FSM is away from IDLE
module bram_pingpong_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              full_1,
  input  logic              full_2,
  output logic              rd_en_1,
  output logic [ADDR_W-1:0] rd_add_1,
  input  logic [DATA_W-1:0] rd_data_1,
  output logic              rd_en_2,
  output logic [ADDR_W-1:0] rd_add_2,
  input  logic [DATA_W-1:0] rd_data_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              free_1,
  output logic              free_2,
  output logic              busy
);

  localparam int                CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    FLUSH   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                bank2_q, bank2_d;          // 1: BRAM2 is the bank expected next
  logic [CNT_W-1:0]    cnt_q, cnt_d;              // index of the next read to issue
  logic [ADDR_W-1:0]   last_add_1_q, last_add_1_d;
  logic [ADDR_W-1:0]   last_add_2_q, last_add_2_d;
  logic                inflight_q, inflight_d;    // read data arrives on rd_data this cycle
  logic                inflight_last_q, inflight_last_d;
  logic [1:0]          count_q, count_d;          // output FIFO occupancy
  logic [DATA_W-1:0]   out_data_q, out_data_d;    // FIFO head
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   tail_data_q, tail_data_d;  // FIFO second entry
  logic                tail_last_q, tail_last_d;
  logic                free_1_q, free_1_d;
  logic                free_2_q, free_2_d;
  logic                busy_q, busy_d;

  logic                pop_s;
  logic [2:0]          occ_s;
  logic                issue_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [DATA_W-1:0]   cap_data_s;

  assign pop_s      = out_valid_q & out_ready;
  // Occupancy the FIFO will have after this edge, before counting a read issued now.
  assign occ_s      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign rd_addr_s  = BASE + ADDR_W'(cnt_q);
  assign cap_data_s = bank2_q ? rd_data_2 : rd_data_1;

  // Read enables are combinational so the issue decision sees this cycle's pop.
  assign rd_en_1  = issue_s & ~bank2_q;
  assign rd_en_2  = issue_s & bank2_q;
  assign rd_add_1 = bank2_q ? {ADDR_W{1'b0}} : (issue_s ? rd_addr_s : last_add_1_q);
  assign rd_add_2 = bank2_q ? (issue_s ? rd_addr_s : last_add_2_q) : {ADDR_W{1'b0}};

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign free_1    = free_1_q;
  assign free_2    = free_2_q;
  assign busy      = busy_q;

  // FSM next state, read issue, address tracking and free pulses.
  always_comb begin
    state_d         = state_q;
    bank2_d         = bank2_q;
    cnt_d           = cnt_q;
    issue_s         = 1'b0;
    last_add_1_d    = last_add_1_q;
    last_add_2_d    = last_add_2_q;
    case (state_q)
      IDLE: begin
        // Only the expected bank's full flag is looked at.
        if (bank2_q ? full_2 : full_1) begin
          state_d = DRAIN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (occ_s < 3'd2) begin
          issue_s = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = FLUSH;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      FLUSH: begin
        if (pop_s && out_last_q) begin
          state_d = RELEASE;
        end else begin
          state_d = FLUSH;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        bank2_d = ~bank2_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue_s && bank2_q) begin
      last_add_2_d = rd_addr_s;
    end else if (issue_s) begin
      last_add_1_d = rd_addr_s;
    end else begin
      last_add_1_d = last_add_1_q;
    end

    inflight_d      = issue_s;
    inflight_last_d = issue_s & (cnt_q == LAST_IDX);
    free_1_d        = (state_d == RELEASE) & ~bank2_q;
    free_2_d        = (state_d == RELEASE) & bank2_q;
    busy_d          = (state_d != IDLE);
  end

  // Two-entry output FIFO: head drives the stream, tail catches the overlap word.
  always_comb begin
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    case ({inflight_q, pop_s})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          out_data_d = cap_data_s;
          out_last_d = inflight_last_q;
        end else begin
          tail_data_d = cap_data_s;
          tail_last_d = inflight_last_q;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          out_data_d = tail_data_q;
          out_last_d = tail_last_q;
        end else begin
          out_data_d = out_data_q;
        end
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          out_data_d = cap_data_s;
          out_last_d = inflight_last_q;
        end else begin
          out_data_d  = tail_data_q;
          out_last_d  = tail_last_q;
          tail_data_d = cap_data_s;
          tail_last_d = inflight_last_q;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    out_valid_d = (count_d != 2'd0);
  end

  // State and datapath registers; reset drops all buffered and in-flight words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      bank2_q         <= 1'b1;
      cnt_q           <= {CNT_W{1'b0}};
      last_add_1_q    <= {ADDR_W{1'b0}};
      last_add_2_q    <= {ADDR_W{1'b0}};
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      out_data_q      <= {DATA_W{1'b0}};
      out_last_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      tail_data_q     <= {DATA_W{1'b0}};
      tail_last_q     <= 1'b0;
      free_1_q        <= 1'b0;
      free_2_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bank2_q         <= bank2_d;
      cnt_q           <= cnt_d;
      last_add_1_q    <= last_add_1_d;
      last_add_2_q    <= last_add_2_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      out_valid_q     <= out_valid_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
      free_1_q        <= free_1_d;
      free_2_q        <= free_2_d;
      busy_q          <= busy_d;
    end
  end

endmodule

// File: tb/tb_bram_pingpong_reader.sv
// Testbench for bram_pingpong_reader (DEPTH=8, BASE_ADDR=0).
// Expected reads, stream words and free pulses come from a bank-order model:
// banks drain in alternation from BRAM2, each as DEPTH ordered words.
module tb_bram_pingpong_reader;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [1:0]  bank;
    logic [31:0] addr;
  } rd_item_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [31:0] data;
    logic        last;
  } out_item_t;

  logic        clk;
  logic        rst;
  logic        full_1, full_2;
  logic        rd_en_1, rd_en_2;
  logic [31:0] rd_add_1, rd_add_2;
  logic [31:0] rd_data_1, rd_data_2;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        free_1, free_2, busy;

  logic [31:0] mem1 [DEPTH];
  logic [31:0] mem2 [DEPTH];

  rd_item_t    exp_rd[$];
  out_item_t   exp_out[$];
  logic [7:0]  exp_trace[$];
  logic [7:0]  trace[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_reads = 0;
  int          n_acc = 0;
  int          ready_mode = 0;      // 0: always ready, 1: random, 2: never ready
  logic [1:0]  prev_last_bank = 2'd0;

  bram_pingpong_reader #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .full_1(full_1), .full_2(full_2),
    .rd_en_1(rd_en_1), .rd_add_1(rd_add_1), .rd_data_1(rd_data_1),
    .rd_en_2(rd_en_2), .rd_add_2(rd_add_2), .rd_data_2(rd_data_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .free_1(free_1), .free_2(free_2), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM models: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en_1) rd_data_1 <= mem1[rd_add_1[2:0]];
    if (rd_en_2) rd_data_2 <= mem2[rd_add_2[2:0]];
  end

  // Hard stop in case something outside the bounded loops hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_rd.delete();
    exp_out.delete();
    exp_trace.delete();
    trace.delete();
    prev_last_bank = 2'd0;
  endtask

  task automatic fill_bank(input int b);
    for (int i = 0; i < DEPTH; i++) begin
      if (b == 1) mem1[i] = $urandom;
      else        mem2[i] = $urandom;
    end
  endtask

  // Append one full bank hand-off to the model.
  task automatic expect_bank(input int b);
    logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = (b == 1) ? mem1[i] : mem2[i];
      exp_rd.push_back('{bank: 2'(b), addr: 32'(i)});
      exp_out.push_back('{bank: 2'(b), data: d, last: (i == DEPTH - 1)});
      exp_trace.push_back(8'(b));
    end
    exp_trace.push_back(8'h10 | 8'(b));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en_1"},   64'(rd_en_1),   64'd0);
    chk({tag, "_rd_en_2"},   64'(rd_en_2),   64'd0);
    chk({tag, "_rd_add_1"},  64'(rd_add_1),  64'd0);
    chk({tag, "_rd_add_2"},  64'(rd_add_2),  64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_free_1"},    64'(free_1),    64'd0);
    chk({tag, "_free_2"},    64'(free_2),    64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  // Per-cycle observation against the model (called at the falling edge).
  task automatic monitor();
    rd_item_t  r;
    out_item_t o;
    logic [1:0]  b;
    logic [31:0] a, other;
    chk("free_1_timing", 64'(free_1), 64'(prev_last_bank == 2'd1));
    chk("free_2_timing", 64'(free_2), 64'(prev_last_bank == 2'd2));
    prev_last_bank = 2'd0;
    if (free_1) begin trace.push_back(8'h11); full_1 = 1'b0; end
    if (free_2) begin trace.push_back(8'h12); full_2 = 1'b0; end
    chk("rd_en_exclusive", 64'(rd_en_1 & rd_en_2), 64'd0);
    if (rd_en_1 || rd_en_2) begin
      b     = rd_en_1 ? 2'd1 : 2'd2;
      a     = rd_en_1 ? rd_add_1 : rd_add_2;
      other = rd_en_1 ? rd_add_2 : rd_add_1;
      n_reads++;
      trace.push_back({6'd0, b});
      chk("rd_add_inactive", 64'(other), 64'd0);
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", {30'd0, b, a}, 64'd0);
      end else begin
        r = exp_rd.pop_front();
        chk("rd_bank", 64'(b), 64'(r.bank));
        chk("rd_add",  64'(a), 64'(r.addr));
      end
    end
    if (out_valid && out_ready) begin
      n_acc++;
      if (exp_out.size() == 0) begin
        chk("out_unexpected", 64'(out_data), 64'hdead_0000_0000);
      end else begin
        o = exp_out.pop_front();
        chk("out_data", 64'(out_data), 64'(o.data));
        chk("out_last", 64'(out_last), 64'(o.last));
        if (o.last) prev_last_bank = o.bank;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while ((exp_out.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done_in_budget"}, 64'(n < budget), 64'd1);
    chk({tag, "_reads_left"}, 64'(exp_rd.size()), 64'd0);
  endtask

  task automatic check_trace(input string tag);
    int m;
    chk({tag, "_trace_len"}, 64'(trace.size()), 64'(exp_trace.size()));
    m = (trace.size() < exp_trace.size()) ? trace.size() : exp_trace.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_trace"}, 64'(trace[i]), 64'(exp_trace[i]));
    end
    trace.delete();
    exp_trace.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    full_1 = 1'b0;
    full_2 = 1'b0;
    ready_mode = 0;
    out_ready = 1'b1;
    #2;
    check_zero(tag);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    full_1 = 1'b0;
    full_2 = 1'b0;
    out_ready = 1'b1;
    rd_data_1 = 32'd0;
    rd_data_2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = 32'd0;
      mem2[i] = 32'd0;
    end
    #1;

    // T1: single BRAM2 drain with fixed contents, cycle-exact.
    do_reset("t1_reset");
    for (int i = 0; i < DEPTH; i++) mem2[i] = 32'h10 + 32'(i);
    expect_bank(2);
    full_2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("t1_rd_en_2", 64'(rd_en_2), 64'(k <= 8));
      chk("t1_rd_en_1", 64'(rd_en_1), 64'd0);
      chk("t1_valid",   64'(out_valid), 64'(k >= 3 && k <= 10));
      chk("t1_last",    64'(out_valid & out_last), 64'(k == 10));
      if (k >= 3 && k <= 10) chk("t1_data", 64'(out_data), 64'h10 + 64'(k - 3));
      chk("t1_free_2",  64'(free_2), 64'(k == 11));
      chk("t1_busy",    64'(busy), 64'(k <= 11));
    end
    run_until_done("t1", 20);
    check_trace("t1");

    // T2: BRAM1 full first is ignored until BRAM2 has been drained.
    do_reset("t2_reset");
    fill_bank(1);
    fill_bank(2);
    full_1 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      chk("t2_idle_busy", 64'(busy), 64'd0);
    end
    expect_bank(2);
    expect_bank(1);
    full_2 = 1'b1;
    run_until_done("t2", 200);
    check_trace("t2");

    // T3: both full together, then the pointer is back at BRAM2.
    do_reset("t3_reset");
    fill_bank(1);
    fill_bank(2);
    expect_bank(2);
    expect_bank(1);
    full_1 = 1'b1;
    full_2 = 1'b1;
    run_until_done("t3a", 200);
    check_trace("t3a");
    fill_bank(1);
    full_1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("t3_wait_bram2", 64'(busy), 64'd0);
    end
    fill_bank(2);
    expect_bank(2);
    expect_bank(1);
    full_2 = 1'b1;
    run_until_done("t3b", 200);
    check_trace("t3b");

    // T4: random backpressure.
    do_reset("t4_reset");
    fill_bank(2);
    expect_bank(2);
    ready_mode = 1;
    full_2 = 1'b1;
    run_until_done("t4", 400);
    check_trace("t4");

    // T5: consumer never ready: two reads, then the stream holds word 0.
    do_reset("t5_reset");
    fill_bank(2);
    expect_bank(2);
    ready_mode = 2;
    full_2 = 1'b1;
    base = n_reads;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (k >= 3) begin
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_hold",  64'(out_data), 64'(mem2[0]));
      end
    end
    chk("t5_reads", 64'(n_reads - base), 64'd2);
    ready_mode = 0;
    run_until_done("t5", 100);
    check_trace("t5");

    // T6: reset mid-drain, then restart from BRAM2 address 0.
    do_reset("t6_reset");
    fill_bank(1);
    fill_bank(2);
    expect_bank(2);
    full_2 = 1'b1;
    base = n_acc;
    for (int k = 0; k < 40 && (n_acc - base) < 3; k++) cycle();
    chk("t6_accepted", 64'(n_acc - base), 64'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero("t6_mid");
    clear_model();
    full_1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_bank(2);
    expect_bank(1);
    rst = 1'b1;
    run_until_done("t6", 200);
    check_trace("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
